// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED afterglow stage: brightness width,
// full-scale value and the saturating decay helper used by every channel.
package led_fade_pkg;

  localparam int BRIGHT_W = 8;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 8'hFF;
  localparam int PWM_W = 8;

  typedef logic [BRIGHT_W-1:0] bright_t;
  typedef logic [PWM_W-1:0] pwm_t;

  // Subtract step from level, clamping at zero instead of wrapping.
  function automatic bright_t sat_sub(input bright_t level, input bright_t step);
    return (level > step) ? bright_t'(level - step) : '0;
  endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One afterglow channel: holds the brightness level, reloads it to full
// scale while the input bit is lit, decays it by STEP on each tick and
// compares it against the shared PWM ramp to drive one LED pin.
module led_fade_ch
  import led_fade_pkg::*;
#(
  parameter int STEP = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                load,
  input  logic                tick,
  input  logic [PWM_W-1:0]    pwm,
  output logic                led
);

  localparam bright_t STEP_B = bright_t'(STEP);

  bright_t bright;
  bright_t bright_next;

  // Next brightness: a lit input beats a coincident decay tick.
  always_comb begin
    bright_next = bright;
    if (load) begin
      bright_next = BRIGHT_MAX;
    end else if (tick) begin
      bright_next = sat_sub(bright, STEP_B);
    end
  end

  // Brightness register; reset throws away any fade in progress.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      bright <= '0;
    end else begin
      bright <= bright_next;
    end
  end

  // Registered PWM compare; full scale still drops out for the pwm=255 slot.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      led <= 1'b0;
    end else begin
      led <= (bright > pwm);
    end
  end

endmodule

// File: rtl/led_fade.sv
// LED afterglow stage between the prescaled counter and the board LEDs.
// Owns the shared PWM ramp and the decay prescaler; each of the eight
// channels keeps its own brightness and output register.
module led_fade
  import led_fade_pkg::*;
#(
  parameter int DECAY_N = 16,
  parameter int STEP    = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [7:0] din,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7
);

  pwm_t               pwm;
  logic [DECAY_N-1:0] pre;
  logic               tick;
  logic [7:0]         led;

  // Free-running PWM ramp shared by all channels; wraps 255 -> 0.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + PWM_W'(1);
    end
  end

  // Decay prescaler; its all-ones state marks the single tick cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pre <= '0;
    end else begin
      pre <= pre + DECAY_N'(1);
    end
  end

  assign tick = &pre;

  for (genvar i = 0; i < 8; i++) begin : g_ch
    led_fade_ch #(
      .STEP (STEP)
    ) u_ch (
      .CLK  (CLK),
      .RSTN (RSTN),
      .load (din[i]),
      .tick (tick),
      .pwm  (pwm),
      .led  (led[i])
    );
  end

  assign LED0 = led[0];
  assign LED1 = led[1];
  assign LED2 = led[2];
  assign LED3 = led[3];
  assign LED4 = led[4];
  assign LED5 = led[5];
  assign LED6 = led[6];
  assign LED7 = led[7];

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade: two instances (STEP=64 and STEP=200, both with a
// 16-clock decay tick) checked every cycle against a cycle-count model.
module tb_led_fade;

  localparam int TICK_P = 16;
  localparam int STEP_A = 64;
  localparam int STEP_B = 200;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] din_a = 8'h00;
  logic [7:0] din_b = 8'h00;
  logic [7:0] obs_a, obs_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  led_fade #(.DECAY_N(4), .STEP(STEP_A)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .din(din_a),
    .LED0(obs_a[0]), .LED1(obs_a[1]), .LED2(obs_a[2]), .LED3(obs_a[3]),
    .LED4(obs_a[4]), .LED5(obs_a[5]), .LED6(obs_a[6]), .LED7(obs_a[7])
  );

  led_fade #(.DECAY_N(4), .STEP(STEP_B)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .din(din_b),
    .LED0(obs_b[0]), .LED1(obs_b[1]), .LED2(obs_b[2]), .LED3(obs_b[3]),
    .LED4(obs_b[4]), .LED5(obs_b[5]), .LED6(obs_b[6]), .LED7(obs_b[7])
  );

  // Reference: cycles since reset give pwm and tick by plain arithmetic.
  int         cnt = 0;
  int         br_a [8];
  int         br_b [8];
  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;

  always @(posedge CLK) begin
    bit tk;
    int pw;
    if (!RSTN) begin
      cnt = 0;
      exp_a = 8'h00;
      exp_b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        br_a[i] = 0;
        br_b[i] = 0;
      end
    end else begin
      tk = ((cnt % TICK_P) == TICK_P - 1);
      pw = cnt % 256;
      for (int i = 0; i < 8; i++) begin
        exp_a[i] = (br_a[i] > pw);
        exp_b[i] = (br_b[i] > pw);
        if (din_a[i])  br_a[i] = 255;
        else if (tk)   br_a[i] = (br_a[i] - STEP_A < 0) ? 0 : br_a[i] - STEP_A;
        if (din_b[i])  br_b[i] = 255;
        else if (tk)   br_b[i] = (br_b[i] - STEP_B < 0) ? 0 : br_b[i] - STEP_B;
      end
      cnt = cnt + 1;
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      n_cmp++;
      assert (obs_a === exp_a) else begin
        n_err++;
        $error("FAIL leds_a cnt=%0d observed=%h expected=%h", cnt, obs_a, exp_a);
      end
      n_cmp++;
      assert (obs_b === exp_b) else begin
        n_err++;
        $error("FAIL leds_b cnt=%0d observed=%h expected=%h", cnt, obs_b, exp_b);
      end
    end
  endtask

  // Count LED0 of instance A over 256 consecutive samples.
  task automatic duty0(input int expected, input string tag);
    int on;
    on = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge CLK);
      on += int'(obs_a[0]);
    end
    n_cmp++;
    assert (on === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, on, expected);
    end
  endtask

  initial begin
    // Reset held with inputs lit: everything must stay dark.
    RSTN = 1'b0; din_a = 8'hFF; din_b = 8'hFF;
    step(3);
    RSTN = 1'b1;
    step(4);
    // Single-cycle pulse on bit 0, then let it fade through several ticks.
    din_a = 8'h01; din_b = 8'h01;
    step(1);
    din_a = 8'h00; din_b = 8'h00;
    step(120);
    // Collision: raise bit 5 exactly in a tick cycle while it is fading.
    din_a = 8'h20;
    step(1);
    din_a = 8'h00;
    while ((cnt % TICK_P) != TICK_P - 1) step(1);
    din_a = 8'h20; din_b = 8'h20;
    step(1);
    din_a = 8'h00; din_b = 8'h00;
    step(40);
    // Reset in the middle of a fade on bit 2.
    din_a = 8'h04; din_b = 8'h04;
    step(1);
    din_a = 8'h00; din_b = 8'h00;
    step(20);
    RSTN = 1'b0;
    step(1);
    RSTN = 1'b1;
    step(300);
    // Full-scale and off duty over a whole pwm period.
    din_a = 8'h01;
    step(4);
    duty0(255, "duty_full");
    din_a = 8'h00;
    step(120);
    duty0(0, "duty_off");
    // Randomized traffic with sparse input pulses and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 8; i++) begin
        din_a[i] = ($urandom_range(0, 39) == 0);
        din_b[i] = ($urandom_range(0, 39) == 0);
      end
      RSTN = ($urandom_range(0, 499) != 0);
      step(1);
    end
    RSTN = 1'b1; din_a = 8'h00; din_b = 8'h00;
    step(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_fade.md
# led_fade

Downstream display stage for the 8-bit prescaled counter. It takes the counter's 8 LED-level outputs and drives the board LEDs with a PWM "afterglow". A lit bit shows at full brightness. When the bit drops, that LED fades linearly to off instead of switching off at once. It sits between the counter and the physical LED pins on the icezum board.

## Interface
Parameters:
- DECAY_N, default 16: prescaler bits for the decay tick; one tick every 2^DECAY_N clocks.
- STEP, default 16: brightness decrement per tick (1..255).

Ports:
- CLK, input, 1: system clock; single clock domain.
- RSTN, input, 1: reset; synchronous, active-low.
- din, input, 8: LED levels from the counter stage, same clock domain; bit i maps to LEDi.
- LED0..LED7, output, 1 each: PWM-driven LED pins.

## Operation
- Per-channel state is bright[i], 8-bit unsigned; 0 = off, 255 = max.
- pwm is an 8-bit free-running counter, +1 every clock, wraps 255->0.
- pre is a DECAY_N-bit free-running counter.
  - tick = (pre == all-ones), asserted for one cycle per 2^DECAY_N clocks.
- Channel update each clock, in priority order:
  - din[i]=1: bright[i] <= 255.
  - else if tick: bright[i] <= (bright[i] > STEP) ? bright[i]-STEP : 0. Saturating; never wraps below 0.
  - else: hold.
- Simultaneous din[i]=1 and tick: load wins, so bright[i] = 255.
- Output: LEDi <= (bright[i] > pwm), registered.
  - bright 255: LED on 255 of every 256 cycles. One off cycle at pwm=255 is accepted.
  - bright 0: LED constantly off.
- Channels are independent and share pwm, pre and tick.
- Reset (RSTN=0 at a rising edge): bright[*]=0, pwm=0, pre=0, LED0..7=0.
  - Reset mid-fade discards all brightness.
  - din is ignored while RSTN=0.

## Timing
- Latency din[i] rise -> LEDi high is 2 cycles: bright loads at edge t+1, LED registers at t+2. LEDi is high at t+2 unless pwm=255 in cycle t+1.
- First possible decrement after din[i] falls comes on the next tick. Full fade from 255 takes ceil(255/STEP) ticks. With defaults that is 16 ticks, about 1.05M clocks.
- Duty cycle of LEDi = bright[i]/256, measured over any aligned 256-cycle pwm period in which bright[i] is constant.
- After reset release: pwm=0 and pre=0 in the first active cycle; the first tick comes 2^DECAY_N-1 clocks later.

## Structure
- Shared package: BRIGHT_W=8, BRIGHT_MAX=8'hFF, and a helper for saturating subtraction.
- Top level holds pwm, pre and tick generation.
- Sub-module led_fade_ch, instantiated 8 times:
  - inputs: CLK, RSTN, load (din[i]), tick, pwm;
  - output: led;
  - parameter: STEP;
  - holds bright[i] and the output register.

## Test plan
Run with DECAY_N=4 (tick every 16 clocks) and STEP=64 unless noted.
- Reset: hold RSTN=0 for 3 cycles with din=8'hFF -> LED0..7=0, pwm=0 and all bright=0 on every cycle; after release, din=8'hFF -> all LEDs high 2 cycles later.
- Fade: din[0]=1 for 1 cycle, then 0 -> bright[0] reads 255, 191, 127, 63, 0 on successive ticks (STEP=64); after that LED0 stays 0.
- Duty check: force bright[3]=128 (din[3]=0, no tick within the window) -> LED3 high for exactly 128 of 256 cycles over one pwm period.
- Collision: assert din[5]=1 in the same cycle that tick=1 while bright[5]=100 -> bright[5]=255 on the next cycle, not 36.
- Saturation: STEP=200, bright=255, din=0 -> bright values 55, then 0, then stays at 0 on later ticks with no wrap.
- Reset mid-fade: assert RSTN=0 for 1 cycle while bright[2]=127 -> bright[2]=0 and LED2=0 on the next cycle, with no residual glow afterwards.
